// File: rtl/param_sha256_if.sv
// Bundles the hash-request handshake and the single-port word memory bus of param_sha256.
// The slave view belongs to the hashing core; the master view belongs to the requester and memory.
interface param_sha256_if;
    logic        start;
    logic [15:0] message_addr;
    logic [15:0] output_addr;
    logic        done;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output start, message_addr, output_addr, mem_read_data,
        input  done, mem_we, mem_addr, mem_write_data
    );

    modport slave (
        input  start, message_addr, output_addr, mem_read_data,
        output done, mem_we, mem_addr, mem_write_data
    );
endinterface

// File: rtl/param_sha256.sv
// SHA-256 of a fixed-length (NUM_OF_WORDS x 32-bit) message read from word memory.
// The 8-word digest is written back to memory; one compression round runs per clock.
module param_sha256 #(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic          mem_clk,
    param_sha256_if.slave bus
);

    // Padded block count: message + 0x80000000 marker + 64-bit length must fit.
    localparam int          BLOCKS   = (NUM_OF_WORDS + 18) / 16;
    localparam logic [12:0] N_WORDS  = 13'(NUM_OF_WORDS);
    localparam logic [8:0]  LAST_BLK = 9'(BLOCKS - 1);
    localparam logic [31:0] LEN_BITS = 32'(NUM_OF_WORDS * 32);

    generate
        if (NUM_OF_WORDS < 1 || NUM_OF_WORDS > 4095) begin : g_bad_num_of_words
            $error("param_sha256: NUM_OF_WORDS must lie in 1..4095");
        end
    endgenerate

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        UPDATE  = 3'd3,
        WRITE   = 3'd4
    } state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t      state_reg, state_next;
    logic [6:0]  cnt_reg, cnt_next;
    logic [8:0]  block_reg, block_next;
    logic [15:0] msg_base_reg, out_base_reg;
    logic        accept;

    logic [31:0] h_reg  [8];
    logic [31:0] wv_reg [8];
    logic [31:0] w_reg  [16];
    logic [31:0] h_sum    [8];
    logic [31:0] wv_round [8];

    assign mem_clk = clk;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            block_reg    <= '0;
            msg_base_reg <= '0;
            out_base_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            block_reg <= block_next;
            if (accept) begin
                msg_base_reg <= bus.message_addr;
                out_base_reg <= bus.output_addr;
            end
        end
    end

    always_comb begin
        state_next         = state_reg;
        cnt_next           = cnt_reg;
        block_next         = block_reg;
        accept             = 1'b0;
        bus.done           = 1'b0;
        bus.mem_we         = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_write_data = '0;
        case (state_reg)
            IDLE: begin
                bus.done = 1'b1;
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = LOAD;
                    cnt_next   = '0;
                    block_next = '0;
                end
            end
            LOAD: begin
                // Address for word 16*block+cnt; cycle 16 only drains the last read.
                if (cnt_reg != 7'd16)
                    bus.mem_addr = msg_base_reg + 16'({block_reg, cnt_reg[3:0]});
                if (cnt_reg == 7'd16) begin
                    state_next = COMPUTE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 7'd1;
                end
            end
            COMPUTE: begin
                if (cnt_reg == 7'd63) begin
                    state_next = UPDATE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 7'd1;
                end
            end
            UPDATE: begin
                cnt_next = '0;
                if (block_reg == LAST_BLK) begin
                    state_next = WRITE;
                end else begin
                    state_next = LOAD;
                    block_next = block_reg + 9'd1;
                end
            end
            WRITE: begin
                bus.mem_we         = 1'b1;
                bus.mem_addr       = out_base_reg + {13'd0, cnt_reg[2:0]};
                bus.mem_write_data = h_reg[cnt_reg[2:0]];
                if (cnt_reg == 7'd7) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 7'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- message schedule ----------------
    logic [3:0]  r4, r4_m2, r4_m7, r4_m15, cap_t;
    logic [12:0] cap_g;
    logic [31:0] load_word, w_t;
    logic        w_we;
    logic [3:0]  w_idx;
    logic [31:0] w_din;

    assign r4     = cnt_reg[3:0];
    assign r4_m2  = r4 - 4'd2;
    assign r4_m7  = r4 - 4'd7;
    assign r4_m15 = r4 - 4'd15;
    assign cap_t  = cnt_reg[3:0] - 4'd1;
    assign cap_g  = {block_reg, cap_t};

    // Words past the message are synthesised here, never taken from memory.
    always_comb begin
        load_word = '0;
        if (cap_g < N_WORDS)
            load_word = bus.mem_read_data;
        else if (cap_g == N_WORDS)
            load_word = 32'h8000_0000;
        else if (block_reg == LAST_BLK && cap_t == 4'd15)
            load_word = LEN_BITS;
    end

    always_comb begin
        w_t = w_reg[r4];
        if (cnt_reg[5:4] != 2'b00)
            w_t = ssig1(w_reg[r4_m2]) + w_reg[r4_m7] + ssig0(w_reg[r4_m15]) + w_reg[r4];
    end

    always_comb begin
        w_we  = 1'b0;
        w_idx = r4;
        w_din = w_t;
        if (state_reg == LOAD && cnt_reg != 7'd0) begin
            w_we  = 1'b1;
            w_idx = cap_t;
            w_din = load_word;
        end else if (state_reg == COMPUTE) begin
            w_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we)
            w_reg[w_idx] <= w_din;
    end

    // ---------------- compression round ----------------
    logic [31:0] big_s0, big_s1, ch, maj, t1, t2;

    always_comb begin
        big_s1 = rotr(wv_reg[4], 6) ^ rotr(wv_reg[4], 11) ^ rotr(wv_reg[4], 25);
        ch     = (wv_reg[4] & wv_reg[5]) ^ (~wv_reg[4] & wv_reg[6]);
        t1     = wv_reg[7] + big_s1 + ch + K[cnt_reg[5:0]] + w_t;
        big_s0 = rotr(wv_reg[0], 2) ^ rotr(wv_reg[0], 13) ^ rotr(wv_reg[0], 22);
        maj    = (wv_reg[0] & wv_reg[1]) ^ (wv_reg[0] & wv_reg[2]) ^ (wv_reg[1] & wv_reg[2]);
        t2     = big_s0 + maj;
    end

    assign wv_round[0] = t1 + t2;
    assign wv_round[1] = wv_reg[0];
    assign wv_round[2] = wv_reg[1];
    assign wv_round[3] = wv_reg[2];
    assign wv_round[4] = wv_reg[3] + t1;
    assign wv_round[5] = wv_reg[4];
    assign wv_round[6] = wv_reg[5];
    assign wv_round[7] = wv_reg[6];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_hsum
            assign h_sum[gi] = h_reg[gi] + wv_reg[gi];
        end
    endgenerate

    // IVs are reloaded on every accepted start so no prior digest leaks in.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (accept) begin
                h_reg[i]  <= IV[i];
                wv_reg[i] <= IV[i];
            end else if (state_reg == COMPUTE) begin
                wv_reg[i] <= wv_round[i];
            end else if (state_reg == UPDATE) begin
                h_reg[i]  <= h_sum[i];
                wv_reg[i] <= h_sum[i];
            end
        end
    end

endmodule

// File: tb/tb_param_sha256.sv
// Bench for param_sha256: four instances (N=1,13,14,20) share one word memory;
// digests are compared with a plain SHA-256 model built from the padding rules.
module tb_param_sha256;

    localparam int NDUT = 4;
    localparam int NS [NDUT] = '{1, 13, 14, 20};

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] ABCD_DIGEST [8] = '{
        32'h88d4266f, 32'hd4e6338d, 32'h13b845fc, 32'hf289579d,
        32'h209c8978, 32'h23b9217d, 32'ha3e16193, 32'h6f031589
    };

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic [NDUT-1:0] start_v = '0;
    logic [15:0]     maddr = '0;
    logic [15:0]     oaddr = '0;
    logic [31:0]     rd_data;
    logic [NDUT-1:0] done_w, we_w, mclk_w;
    logic [15:0]     addr_w [NDUT];
    logic [31:0]     wd_w   [NDUT];
    int              sel = 0;

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            param_sha256_if bus_if ();
            assign bus_if.start         = start_v[gi];
            assign bus_if.message_addr  = maddr;
            assign bus_if.output_addr   = oaddr;
            assign bus_if.mem_read_data = rd_data;
            assign done_w[gi] = bus_if.done;
            assign we_w[gi]   = bus_if.mem_we;
            assign addr_w[gi] = bus_if.mem_addr;
            assign wd_w[gi]   = bus_if.mem_write_data;
            param_sha256 #(.NUM_OF_WORDS(NS[gi])) dut (
                .clk     (clk),
                .reset_n (reset_n),
                .mem_clk (mclk_w[gi]),
                .bus     (bus_if)
            );
        end
    endgenerate

    // Message memory (read-only for the DUT) plus a log of every write the DUT issues.
    logic [31:0] mem [65536];
    logic [47:0] wr_log [$];
    int          stray_writes = 0;

    always @(posedge clk) begin
        rd_data <= mem[addr_w[sel]];
        if (we_w[sel]) begin
            wr_log.push_back({addr_w[sel], wd_w[sel]});
            $display("write dut%0d addr=%h data=%h", sel, addr_w[sel], wd_w[sel]);
        end
        for (int i = 0; i < NDUT; i++)
            if (i != sel && we_w[i] !== 1'b0) stray_writes++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference SHA-256: pad the word list, then process 512-bit blocks.
    task automatic golden(input logic [31:0] msg [$], output logic [31:0] dig [8]);
        logic [31:0] p [$];
        logic [31:0] w [64];
        logic [31:0] hv [8];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        p = msg;
        p.push_back(32'h8000_0000);
        while (p.size() % 16 != 14) p.push_back('0);
        p.push_back('0);
        p.push_back(32'(msg.size() * 32));
        hv = IV;
        for (int b = 0; b < p.size() / 16; b++) begin
            for (int t = 0; t < 64; t++) begin
                if (t < 16) w[t] = p[b * 16 + t];
                else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                          + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            end
            v = hv;
            for (int t = 0; t < 64; t++) begin
                t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
                t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                   + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                for (int i = 7; i > 0; i--) v[i] = v[i-1];
                v[4] = v[4] + t1;
                v[0] = t1 + t2;
            end
            for (int i = 0; i < 8; i++) hv[i] = hv[i] + v[i];
        end
        dig = hv;
    endtask

    // Random message at base, with random garbage after it so padding must be generated.
    task automatic fill(input logic [15:0] base, input int n, output logic [31:0] msg [$]);
        logic [31:0] v;
        msg = {};
        for (int i = 0; i < n + 24; i++) begin
            v = $urandom;
            mem[16'(base + i)] = v;
            if (i < n) msg.push_back(v);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first IDLE cycle afterwards.
    task automatic run_hash(input int idx, input logic [15:0] ma, input logic [15:0] oa,
                            input logic [31:0] exp_dig [8], input bit disturb);
        int low, log0, nbits, exp_low;
        logic [47:0] entry;
        nbits   = NS[idx] * 32 + 1 + 64;
        exp_low = ((nbits + 511) / 512) * 82 + 8;
        sel   = idx;
        maddr = ma;
        oaddr = oa;
        log0  = wr_log.size();
        start_v = NDUT'(1 << idx);
        @(negedge clk);
        start_v = '0;
        low = 0;
        while (done_w[idx] == 1'b0 && low < 6000) begin
            low++;
            if (disturb && low == 50) begin
                start_v = NDUT'(1 << idx);
                maddr   = ma ^ 16'h5a5a;
            end else begin
                start_v = '0;
            end
            @(negedge clk);
        end
        start_v = '0;
        $display("hash dut%0d N=%0d msg=%h out=%h done_low=%0d writes=%0d",
                 idx, NS[idx], ma, oa, low, wr_log.size() - log0);
        check($sformatf("done_low_dut%0d", idx), 64'(low), 64'(exp_low));
        check($sformatf("write_count_dut%0d", idx), 64'(wr_log.size() - log0), 64'd8);
        for (int k = 0; k < 8; k++) begin
            entry = (log0 + k < wr_log.size()) ? wr_log[log0 + k] : 48'h0;
            check($sformatf("digest_dut%0d_w%0d", idx, k), 64'(entry), 64'({16'(oa + k), exp_dig[k]}));
        end
    endtask

    // Starts a hash and pulls reset_n low between clock edges after at_cycle low cycles.
    task automatic reset_during(input int idx, input logic [15:0] ma, input logic [15:0] oa,
                                input int at_cycle, input bit expect_we);
        int log0;
        sel = idx;
        maddr = ma;
        oaddr = oa;
        start_v = NDUT'(1 << idx);
        @(negedge clk);
        start_v = '0;
        repeat (at_cycle - 1) @(negedge clk);
        check($sformatf("we_before_reset_dut%0d", idx), 64'(we_w[idx]), 64'(expect_we));
        #2 reset_n = 1'b0;
        #1;
        check("reset_done", 64'(done_w[idx]), 64'd1);
        check("reset_we", 64'(we_w[idx]), 64'd0);
        check("reset_addr", 64'(addr_w[idx]), 64'd0);
        check("reset_wdata", 64'(wd_w[idx]), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        log0 = wr_log.size();
        repeat (20) @(negedge clk);
        check("no_write_after_reset", 64'(wr_log.size() - log0), 64'd0);
        check("idle_after_reset", 64'(done_w[idx]), 64'd1);
        $display("reset at cycle %0d of dut%0d hash", at_cycle, idx);
    endtask

    logic [31:0] msg [$];
    logic [31:0] dig [8];
    logic [15:0] ra, ro;
    int          ri;

    initial begin
        #3 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("rst_done_dut%0d", i), 64'(done_w[i]), 64'd1);
            check($sformatf("rst_we_dut%0d", i), 64'(we_w[i]), 64'd0);
            check($sformatf("rst_addr_dut%0d", i), 64'(addr_w[i]), 64'd0);
            check($sformatf("rst_wdata_dut%0d", i), 64'(wd_w[i]), 64'd0);
        end
        check("mem_clk_low", 64'(mclk_w[0]), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1 check("mem_clk_high", 64'(mclk_w[3]), 64'd1);
        @(negedge clk);

        // "abcd" single-word message against the published digest
        mem[16'h0000] = 32'h61626364;
        run_hash(0, 16'h0000, 16'h0100, ABCD_DIGEST, 1'b0);

        // N=20 random, then an immediate back-to-back start on the same instance
        fill(16'h0000, 20, msg); golden(msg, dig);
        run_hash(3, 16'h0000, 16'h0200, dig, 1'b0);
        fill(16'h0040, 20, msg); golden(msg, dig);
        run_hash(3, 16'h0040, 16'h0210, dig, 1'b0);

        // One-block / two-block boundary
        fill(16'h1000, 13, msg); golden(msg, dig);
        run_hash(1, 16'h1000, 16'h0300, dig, 1'b0);
        fill(16'h2000, 14, msg); golden(msg, dig);
        run_hash(2, 16'h2000, 16'h0310, dig, 1'b0);

        // Start pulse plus address change mid-hash must be ignored
        fill(16'h3000, 20, msg); golden(msg, dig);
        fill(16'h3000 ^ 16'h5a5a, 20, msg);
        fill(16'h3000, 20, msg); golden(msg, dig);
        run_hash(3, 16'h3000, 16'h0400, dig, 1'b1);

        // Message wrapping past the top of the address space
        fill(16'hFFF8, 20, msg); golden(msg, dig);
        run_hash(3, 16'hFFF8, 16'h0500, dig, 1'b0);

        // Reset mid-COMPUTE of block 0, then a clean hash
        fill(16'h4000, 20, msg); golden(msg, dig);
        reset_during(3, 16'h4000, 16'h0600, 30, 1'b0);
        run_hash(3, 16'h4000, 16'h0600, dig, 1'b0);

        // Reset mid-WRITE (N=1: WRITE occupies low cycles 83..90)
        fill(16'h5000, 1, msg); golden(msg, dig);
        reset_during(0, 16'h5000, 16'h0700, 85, 1'b1);
        run_hash(0, 16'h5000, 16'h0700, dig, 1'b0);

        // Randomized instances and addresses
        for (int r = 0; r < 6; r++) begin
            ri = $urandom_range(0, NDUT - 1);
            ra = 16'($urandom);
            ro = 16'($urandom);
            fill(ra, NS[ri], msg); golden(msg, dig);
            run_hash(ri, ra, ro, dig, 1'b0);
        end

        check("stray_writes", 64'(stray_writes), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
